// File: rtl/pll_lock_reset_sequencer.sv
// PLL reset / lock sequencer running on the free-running reference clock.
// Optional lock-loss interrupt is enabled by defining PLL_LOCK_IRQ_EN.
module pll_lock_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             clear_counts,
  output logic             pll_rst,
  output logic             sys_reset_n,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic             irq
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CYC_W-1:0] RST_LAST     = CYC_W'(PLL_RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state;
  logic [CYC_W-1:0]       cyc_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   timeout_hit;
  logic                   lock_lost;

  assign locked_s    = sync_q[SYNC_STAGES-1];
  assign timeout_hit = (state == WAIT_LOCK) && !locked_s && (cyc_cnt == TIMEOUT_LAST);
  assign lock_lost   = (state == RUN) && !locked_s;
  assign state_o     = state;

  // pll_locked comes from another clock domain; nothing else looks at it directly.
  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= PLL_RESET;
      cyc_cnt     <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
    end else begin
      case (state)
        PLL_RESET: begin
          if (cyc_cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cyc_cnt <= '0;
            pll_rst <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state   <= STABLE;
            cyc_cnt <= '0;
          end else if (timeout_hit) begin
            state   <= PLL_RESET;
            cyc_cnt <= '0;
            pll_rst <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        STABLE: begin
          // Any dropout restarts the stability window without re-resetting the PLL.
          if (!locked_s) begin
            state   <= WAIT_LOCK;
            cyc_cnt <= '0;
          end else if (cyc_cnt == STABLE_LAST) begin
            state       <= RUN;
            cyc_cnt     <= '0;
            sys_reset_n <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        RUN: begin
          if (lock_lost) begin
            state       <= PLL_RESET;
            cyc_cnt     <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
          end
        end
        default: begin
          state       <= PLL_RESET;
          cyc_cnt     <= '0;
          pll_rst     <= 1'b1;
          sys_reset_n <= 1'b0;
        end
      endcase
    end
  end

  // A clear that coincides with an event still records that event.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cur,
                                            input logic inc, input logic clr);
    if (clr)                    return inc ? CNT_W'(1) : '0;
    else if (inc && cur != '1)  return cur + CNT_W'(1);
    else                        return cur;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_loss_cnt <= '0;
      timeout_cnt   <= '0;
    end else begin
      lock_loss_cnt <= bump(lock_loss_cnt, lock_lost, clear_counts);
      timeout_cnt   <= bump(timeout_cnt, timeout_hit, clear_counts);
    end
  end

`ifdef PLL_LOCK_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset_n)          irq <= 1'b0;
    else if (lock_lost)    irq <= 1'b1;
    else if (clear_counts) irq <= 1'b0;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Self-checking bench for pll_lock_reset_sequencer; expectations come from edge-count
// arithmetic on the sequencing rules, with randomized lock delays and dropout lengths.
module tb_pll_lock_reset_sequencer;

  localparam int SYNC     = 2;
  localparam int RST      = 4;
  localparam int TMO      = 64;
  localparam int STB      = 8;
  localparam int CW       = 4;
  localparam int PERIOD_T = RST + TMO;
  localparam int LAT      = SYNC + 1 + STB;
  localparam int MAXC     = (1 << CW) - 1;

`ifdef PLL_LOCK_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          clear_counts = 1'b0;
  logic          pll_rst;
  logic          sys_reset_n;
  logic [1:0]    state_o;
  logic [CW-1:0] lock_loss_cnt;
  logic [CW-1:0] timeout_cnt;
  logic          irq;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int exp_loss = 0;
  bit exp_irq = 1'b0;

  pll_lock_reset_sequencer #(
    .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(RST), .LOCK_TIMEOUT_CYCLES(TMO),
    .LOCK_STABLE_CYCLES(STB), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .clear_counts(clear_counts),
    .pll_rst(pll_rst), .sys_reset_n(sys_reset_n), .state_o(state_o),
    .lock_loss_cnt(lock_loss_cnt), .timeout_cnt(timeout_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic restart();
    reset_n = 1'b0;
    pll_locked = 1'b0;
    clear_counts = 1'b0;
    tick();
    reset_n = 1'b1;
    t = 0;
    exp_loss = 0;
    exp_irq = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pll_locked = 1'($urandom_range(0, 1));
    tick();
    tick();
    checks++;
    if ({state_o, pll_rst, sys_reset_n} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b", {state_o, pll_rst, sys_reset_n}, 4'b0010);
    end
    checks++;
    if ({lock_loss_cnt, timeout_cnt, irq} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_counts: got loss=%0d timeout=%0d irq=%b expected 0/0/0",
               lock_loss_cnt, timeout_cnt, irq);
    end
  endtask

  task automatic test_timeout_saturation();
    int n, p, exp_to, exp_state;
    restart();
    for (int k = 1; k <= PERIOD_T*21 + 5; k++) begin
      clear_counts = (k == PERIOD_T*21);
      tick();
      clear_counts = 1'b0;
      n = t / PERIOD_T;
      p = t % PERIOD_T;
      exp_to = (t >= PERIOD_T*21) ? 1 : ((n > MAXC) ? MAXC : n);
      exp_state = (p < RST) ? 0 : 1;
      checks++;
      if ({state_o, pll_rst, sys_reset_n} !== {2'(exp_state), (p < RST), 1'b0}) begin
        errors++;
        $display("[TB] FAIL timeout_ctrl t=%0d: got %b expected %b", t,
                 {state_o, pll_rst, sys_reset_n}, {2'(exp_state), (p < RST), 1'b0});
      end
      checks++;
      if (timeout_cnt !== CW'(exp_to) || lock_loss_cnt !== '0) begin
        errors++;
        $display("[TB] FAIL timeout_cnt t=%0d: got %0d/%0d expected %0d/0", t,
                 timeout_cnt, lock_loss_cnt, exp_to);
      end
    end
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    checks++;
    if (timeout_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL timeout_clear: got %0d expected 0", timeout_cnt);
    end
  endtask

  task automatic test_lock_to_run(input int d);
    int exp_state;
    restart();
    repeat (RST + d) tick();
    pll_locked = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      exp_state = (k < SYNC + 1) ? 1 : ((k < LAT) ? 2 : 3);
      checks++;
      if ({state_o, pll_rst, sys_reset_n} !== {2'(exp_state), 1'b0, (k >= LAT)}) begin
        errors++;
        $display("[TB] FAIL lock_ctrl d=%0d k=%0d: got %b expected %b", d, k,
                 {state_o, pll_rst, sys_reset_n}, {2'(exp_state), 1'b0, (k >= LAT)});
      end
    end
    checks++;
    if (timeout_cnt !== '0 || lock_loss_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL lock_counts d=%0d: got %0d/%0d expected 0/0", d, timeout_cnt, lock_loss_cnt);
    end
  endtask

  // Entered in RUN with the lock stable; ends back in RUN after relocking.
  task automatic test_lock_loss(input int len, input bit clr_at_loss);
    int entry, exp_state;
    bit exp_sys, exp_rst;
    entry = (len + 3 > 2*RST) ? len + 3 : 2*RST;
    pll_locked = 1'b0;
    for (int k = 1; k <= entry + STB + 1; k++) begin
      clear_counts = clr_at_loss && (k == 3);
      tick();
      clear_counts = 1'b0;
      if (k == 3) begin
        exp_loss = clr_at_loss ? 1 : ((exp_loss == MAXC) ? MAXC : exp_loss + 1);
        exp_irq = IRQ_EN;
      end
      exp_state = (k < 3) ? 3 : (k < 3 + RST) ? 0 : (k < entry) ? 1 : (k < entry + STB) ? 2 : 3;
      exp_sys = (k < 3) || (k >= entry + STB);
      exp_rst = (k >= 3) && (k < 3 + RST);
      checks++;
      if ({state_o, pll_rst, sys_reset_n} !== {2'(exp_state), exp_rst, exp_sys}) begin
        errors++;
        $display("[TB] FAIL loss_ctrl len=%0d k=%0d: got %b expected %b", len, k,
                 {state_o, pll_rst, sys_reset_n}, {2'(exp_state), exp_rst, exp_sys});
      end
      checks++;
      if (lock_loss_cnt !== CW'(exp_loss) || irq !== exp_irq) begin
        errors++;
        $display("[TB] FAIL loss_cnt len=%0d k=%0d: got %0d irq=%b expected %0d irq=%b", len, k,
                 lock_loss_cnt, irq, exp_loss, exp_irq);
      end
      if (k == len) pll_locked = 1'b1;
    end
  endtask

  task automatic test_clear_counts();
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    exp_loss = 0;
    exp_irq = 1'b0;
    checks++;
    if (lock_loss_cnt !== '0 || timeout_cnt !== '0 || irq !== 1'b0 || state_o !== 2'd3) begin
      errors++;
      $display("[TB] FAIL clear_counts: got loss=%0d timeout=%0d irq=%b state=%0d expected 0/0/0/3",
               lock_loss_cnt, timeout_cnt, irq, state_o);
    end
  endtask

  task automatic test_stable_drop(input int s);
    int exp_state;
    restart();
    repeat (RST) tick();
    pll_locked = 1'b1;
    repeat (SYNC + 1 + s) tick();
    pll_locked = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_state = (k < SYNC + 1) ? 2 : 1;
      checks++;
      if ({state_o, pll_rst, sys_reset_n} !== {2'(exp_state), 2'b00}) begin
        errors++;
        $display("[TB] FAIL stable_ctrl s=%0d k=%0d: got %b expected %b", s, k,
                 {state_o, pll_rst, sys_reset_n}, {2'(exp_state), 2'b00});
      end
      checks++;
      if (lock_loss_cnt !== '0 || timeout_cnt !== '0) begin
        errors++;
        $display("[TB] FAIL stable_counts s=%0d k=%0d: got %0d/%0d expected 0/0", s, k,
                 lock_loss_cnt, timeout_cnt);
      end
    end
  endtask

  task automatic test_reset_in_run();
    repeat ($urandom_range(0, 5)) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({state_o, pll_rst, sys_reset_n} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL run_reset_ctrl: got %b expected %b", {state_o, pll_rst, sys_reset_n}, 4'b0010);
    end
    checks++;
    if ({lock_loss_cnt, timeout_cnt, irq} !== '0) begin
      errors++;
      $display("[TB] FAIL run_reset_counts: got loss=%0d timeout=%0d irq=%b expected 0/0/0",
               lock_loss_cnt, timeout_cnt, irq);
    end
  endtask

  initial begin
    test_reset();
    test_timeout_saturation();
    test_lock_to_run(10);
    test_lock_loss(5, 1'b0);
    test_clear_counts();
    repeat (3) begin
      test_lock_to_run(int'($urandom_range(0, 55)));
      test_lock_loss(int'($urandom_range(1, 12)), 1'b0);
      test_lock_loss(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)));
    end
    test_clear_counts();
    test_stable_drop(5);
    repeat (3) test_stable_drop(int'($urandom_range(0, 5)));
    test_lock_to_run(int'($urandom_range(0, 55)));
    test_lock_loss(int'($urandom_range(1, 12)), 1'b0);
    test_reset_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_reset_sequencer.md
Name: pll_lock_reset_sequencer

Overview:
Consumer side of the system PLL's rst/locked interface. It drives the PLL reset, watches the PLL's lock output, and holds the downstream system/SDRAM reset until lock has been stable. It re-resets the PLL on lock timeout or lock loss. It runs on the free-running 50 MHz reference clock, never on a PLL output, and keeps lock-loss and timeout statistics.

Parameters:
SYNC_STAGES, 2, synchronizer depth for pll_locked (min 2)
PLL_RST_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse (min 1)
LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before re-reset
LOCK_STABLE_CYCLES, 1024, consecutive synced-locked cycles required before releasing sys_reset_n
CNT_W, 8, width of statistics counters

Ports:
clk  in  1  50 MHz reference clock, same source as the PLL refclk
reset_n  in  1  synchronous, active-low reset
pll_locked  in  1  PLL lock output, asynchronous to clk
clear_counts  in  1  one-cycle pulse, zeroes statistics counters
pll_rst  out  1  active-high PLL reset, registered
sys_reset_n  out  1  active-low downstream reset, registered
state_o  out  2  current state: 0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN
lock_loss_cnt  out  CNT_W  lock drops seen in RUN, saturating
timeout_cnt  out  CNT_W  WAIT_LOCK timeouts, saturating
irq  out  1  lock-loss interrupt (see Optional Feature)

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=PLL_RESET, cycle counter=0.
  - pll_rst=1, sys_reset_n=0.
  - Both statistics counters=0, synchronizer flops=0, irq=0.
- Sync: locked_s is pll_locked after SYNC_STAGES flops. All decisions use locked_s only.
- PLL_RESET:
  - pll_rst=1, sys_reset_n=0.
  - The counter counts to PLL_RST_CYCLES-1, then the state goes to WAIT_LOCK and the counter clears.
  - pll_rst is high for exactly PLL_RST_CYCLES cycles after reset_n deasserts, and for exactly PLL_RST_CYCLES cycles per re-entry.
- WAIT_LOCK:
  - pll_rst=0, sys_reset_n=0.
  - locked_s=1: go to STABLE, counter=0.
  - Otherwise, at counter=LOCK_TIMEOUT_CYCLES-1: timeout_cnt++ (saturating) and go to PLL_RESET.
- STABLE:
  - sys_reset_n=0.
  - locked_s=0: go to WAIT_LOCK, counter=0. No timeout or loss is counted.
  - locked_s=1 for LOCK_STABLE_CYCLES consecutive cycles: go to RUN.
- RUN:
  - sys_reset_n=1, registered in the same cycle as state=RUN.
  - locked_s=0: lock_loss_cnt++ (saturating) and go to PLL_RESET. sys_reset_n=0 on the next edge, i.e. 1 cycle after locked_s falls.
- Latency: pll_locked rising to sys_reset_n rising = SYNC_STAGES + 1 + LOCK_STABLE_CYCLES cycles.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - clear_counts zeroes both counters.
  - If clear_counts coincides with an increment, the result is 1 for that counter.
- Mid-operation reset_n=0 from any state restarts at PLL_RESET immediately. Counters are cleared.
- pll_locked glitches shorter than one clk period may be missed. This is acceptable.

Optional Feature:
PLL_LOCK_IRQ_EN
- Defined:
  - irq is set high on every RUN→PLL_RESET transition caused by lock loss.
  - irq is sticky until clear_counts=1. Set takes priority if both occur in one cycle.
- Undefined: irq is tied 0, and no irq logic is synthesized. The port remains for interface stability.

Test Plan:
Sim parameters: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=64, LOCK_STABLE_CYCLES=8, CNT_W=4.
1. Release reset_n, pll_locked=0 → pll_rst=1 for exactly 4 cycles, then state_o=1. Repeated pll_rst pulses follow every 4+64 cycles. timeout_cnt increments 1,2,3….
2. Raise pll_locked 10 cycles after pll_rst falls → state_o 1→2 after 2 sync cycles. sys_reset_n rises 2+1+8=11 cycles after the pll_locked edge; state_o=3.
3. In RUN, drop pll_locked for 5 cycles → sys_reset_n=0 3 cycles after the drop, pll_rst=1 for 4 cycles, lock_loss_cnt=1. With PLL_LOCK_IRQ_EN, irq=1 until clear_counts.
4. In STABLE, drop pll_locked at stable count 5 → back to state 1. sys_reset_n stays 0. No counter changes.
5. Force 20 timeouts → timeout_cnt saturates at 15. clear_counts pulsed in the same cycle as the 21st timeout → timeout_cnt=1.
6. Assert reset_n=0 during RUN → next edge: sys_reset_n=0, pll_rst=1, counters=0, irq=0, state_o=0.
